fetch_queue: RTL and testbench
==============================

// Module: fetch_queue
// PURPOSE
//  Instruction-fetch front end feeding the IF/ID buffer. Owns the PC and drives the
//  synchronous instruction memory, one word-addressed fetch per cycle. Holds fetched
//  words with their PC in a small prefetch FIFO and hands them to decode over a
//  valid/ready handshake. A redirect (branch/jump resolved in WB) flushes the queue
//  and any in-flight fetch, then restarts at the target.
// PARAMETERS
//  DEPTH     4        FIFO entries; power of 2, >= 2
//  ADDR_W    8        instruction-memory address width (PC low bits)
//  RESET_PC  32'd0    first PC fetched after reset
// PORTS
//  clock           in   1       rising-edge clock
//  reset_n         in   1       asynchronous, active-low reset
//  redirect_valid  in   1       branchControl from WB: take redirect_pc
//  redirect_pc     in   32      jump/branch target (word address)
//  imem_en         out  1       fetch request this cycle (registered)
//  imem_addr       out  ADDR_W  fetch address = fetch_pc[ADDR_W-1:0]
//  imem_rdata      in   32      instruction word, valid the cycle after imem_en
//  out_valid       out  1       head entry available to decode
//  out_ready       in   1       decode accepts head entry
//  out_instr       out  32      head instruction
//  out_pc          out  32      PC of head instruction
//  fetch_cnt       out  16      instructions delivered (FETCH_STATS_EN)
//  flush_cnt       out  16      entries discarded by redirects (FETCH_STATS_EN)
// BEHAVIOUR
//  Reset: state=IDLE, fetch_pc=RESET_PC, count=0, rd/wr ptr=0, inflight=0,
//   imem_en=0, out_valid=0, out_instr=0, out_pc=0, fetch_cnt=flush_cnt=0.
//  FSM: IDLE -> FETCH (unconditional, 1 cycle); FETCH -> FLUSH on redirect_valid;
//   FLUSH -> FETCH unless redirect_valid again (stay FLUSH, reload target).
//  FETCH: issue (imem_en=1, fetch_pc+=1 mod 2^32) iff count + inflight < DEPTH
//   (pop in same cycle not credited). inflight = imem_en of previous cycle;
//   tag register holds the issued PC.
//  Response: cycle after issue, {imem_rdata, tag} written at wr_ptr; out_valid
//   rises the following cycle. Fetch-to-out_valid latency = 2 cycles.
//  out_valid = (count != 0) & ~redirect_valid; pop when out_valid & out_ready.
//   out_instr/out_pc are the head entry, stable while out_valid & ~out_ready.
//  Simultaneous push and pop: count unchanged; legal when full (credit rule).
//  Pointers wrap modulo DEPTH; fetch_pc wraps 2^32-1 -> 0; imem_addr truncates.
//  Redirect (any state): count, pointers cleared; in-flight response discarded;
//   fetch_pc <= redirect_pc; imem_en=0 next cycle (FLUSH bubble); first target
//   fetch issued 2 cycles after redirect, out_valid 4 cycles after.
//  Redirect beats a same-cycle pop and push. reset_n low mid-operation returns
//   every register to its reset value immediately.
// CONFIGURATION
//  FETCH_STATS_EN defined: fetch_cnt +1 per pop, flush_cnt += count + inflight
//   at each redirect; both saturate at 16'hFFFF.
//  Not defined: no counter registers; fetch_cnt and flush_cnt tied to 0.
// STRUCTURE
//  Shared package pipeline_defs: PC_W=32, INSTR_W=32, IMEM_ADDR_W=8,
//   fetch FSM state encodings (IDLE=2'd0, FETCH=2'd1, FLUSH=2'd2).
//  One sub-module: fetch_fifo (DEPTH x 64-bit {pc,instr}; push/pop/clear,
//   count, full/empty). FSM, credit logic and PC live in fetch_queue.
// TESTING
//  1 Reset release, out_ready=1, imem[i]=i+100 -> PC 0,1,2.. out at 1/cycle from
//    cycle 3, out_instr=100,101,..
//  2 out_ready=0 for 10 cycles -> exactly 4 entries held, imem_en low once
//    count+inflight=4; release -> PCs 0..3 then 4 with no gap or duplicate.
//  3 redirect_pc=40 while 3 queued + 1 inflight -> out_valid 0 at once, none
//    of them delivered, next out_pc=40 four cycles later, flush_cnt=4.
//  4 Back-to-back redirects to 20 then 60 -> only PC 60.. delivered.
//  5 RESET_PC=32'hFFFF_FFFE -> out_pc FFFF_FFFE, FFFF_FFFF, 0; imem_addr FE,FF,00.
//  6 reset_n low with full queue -> out_valid=0, imem_en=0 asynchronously;
//    restart from RESET_PC.

Source files
------------

// File: rtl/fetch_queue_pkg.sv
// pipeline_defs: shared widths, fetch FSM encodings and the prefetch entry layout.
package pipeline_defs;
    localparam int PC_W        = 32;
    localparam int INSTR_W     = 32;
    localparam int IMEM_ADDR_W = 8;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FETCH = 2'd1,
        FLUSH = 2'd2
    } fetch_state_e;

    typedef struct packed {
        logic [PC_W-1:0]    pc;
        logic [INSTR_W-1:0] instr;
    } fetch_entry_t;
endpackage

// File: rtl/fetch_queue_if.sv
// fetch_queue_if: instruction-memory port and decode-side valid/ready handshake.
interface fetch_queue_if #(parameter int ADDR_W = pipeline_defs::IMEM_ADDR_W);
    logic                               imem_en;
    logic [ADDR_W-1:0]                  imem_addr;
    logic [pipeline_defs::INSTR_W-1:0]  imem_rdata;
    logic                               out_valid;
    logic                               out_ready;
    logic [pipeline_defs::INSTR_W-1:0]  out_instr;
    logic [pipeline_defs::PC_W-1:0]     out_pc;

    modport master (
        output imem_en, imem_addr, out_valid, out_instr, out_pc,
        input  imem_rdata, out_ready
    );
    modport slave (
        input  imem_en, imem_addr, out_valid, out_instr, out_pc,
        output imem_rdata, out_ready
    );
endinterface

// File: rtl/fetch_queue_fifo.sv
// fetch_fifo: DEPTH-entry {pc,instr} prefetch FIFO with synchronous clear.
module fetch_fifo
    import pipeline_defs::*;
#(
    parameter int DEPTH = 4
) (
    input  logic                     clock,
    input  logic                     reset_n,
    input  logic                     clear_i,
    input  logic                     push_i,
    input  logic                     pop_i,
    input  fetch_entry_t             data_i,
    output fetch_entry_t             data_o,
    output logic [$clog2(DEPTH):0]   count_o,
    output logic                     full_o,
    output logic                     empty_o
);
    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    fetch_entry_t     mem_q [DEPTH];
    logic [PTR_W-1:0] wr_q, rd_q;
    logic [CNT_W-1:0] count_q;
    logic             wr_en, rd_en;

    assign full_o  = count_q == CNT_W'(DEPTH);
    assign empty_o = count_q == '0;
    assign wr_en   = push_i & (~full_o | pop_i);
    assign rd_en   = pop_i & ~empty_o;
    assign data_o  = mem_q[rd_q];
    assign count_o = count_q;

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
            wr_q    <= '0;
            rd_q    <= '0;
            count_q <= '0;
        end else if (clear_i) begin
            wr_q    <= '0;
            rd_q    <= '0;
            count_q <= '0;
        end else begin
            if (wr_en) begin
                mem_q[wr_q] <= data_i;
                wr_q        <= wr_q + 1'b1;
            end
            if (rd_en) rd_q <= rd_q + 1'b1;
            count_q <= count_q + CNT_W'(wr_en) - CNT_W'(rd_en);
        end
    end
endmodule

// File: rtl/fetch_queue.sv
// fetch_queue: PC owner and prefetch front end feeding decode; redirects flush and restart.
// Optional FETCH_STATS_EN adds saturating delivered/flushed counters.
module fetch_queue
    import pipeline_defs::*;
#(
    parameter int              DEPTH    = 4,
    parameter int              ADDR_W   = IMEM_ADDR_W,
    parameter logic [PC_W-1:0] RESET_PC = '0
) (
    input  logic             clock,
    input  logic             reset_n,
    input  logic             redirect_valid,
    input  logic [PC_W-1:0]  redirect_pc,
    fetch_queue_if.master    bus,
    output logic [15:0]      fetch_cnt,
    output logic [15:0]      flush_cnt
);
    localparam int CNT_W = $clog2(DEPTH) + 1;

    fetch_state_e     state_q, state_d;
    logic [PC_W-1:0]  pc_q, pc_d, tag_q;
    logic             inflight_q, issue, pop, full, empty;
    logic [CNT_W-1:0] count, occ;
    fetch_entry_t     head;

    // Credit counts queued plus in-flight; a same-cycle pop is deliberately not credited.
    assign occ   = count + CNT_W'(inflight_q);
    assign issue = (state_q == FETCH) & ~full & (occ < CNT_W'(DEPTH));
    assign pop   = bus.out_valid & bus.out_ready;

    assign bus.imem_en   = issue;
    assign bus.imem_addr = pc_q[ADDR_W-1:0];
    assign bus.out_valid = ~empty & ~redirect_valid;
    assign bus.out_instr = head.instr;
    assign bus.out_pc    = head.pc;

    always_comb begin
        state_d = redirect_valid ? FLUSH : FETCH;
        pc_d    = redirect_valid ? redirect_pc : issue ? pc_q + 1'b1 : pc_q;
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q    <= IDLE;
            pc_q       <= RESET_PC;
            tag_q      <= '0;
            inflight_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            pc_q       <= pc_d;
            tag_q      <= issue ? pc_q : tag_q;
            inflight_q <= issue & ~redirect_valid;
        end
    end

    fetch_fifo #(.DEPTH(DEPTH)) u_fifo (
        .clock   (clock),
        .reset_n (reset_n),
        .clear_i (redirect_valid),
        .push_i  (inflight_q & ~redirect_valid),
        .pop_i   (pop),
        .data_i  ({tag_q, bus.imem_rdata}),
        .data_o  (head),
        .count_o (count),
        .full_o  (full),
        .empty_o (empty)
    );

`ifdef FETCH_STATS_EN
    logic [15:0] fetch_cnt_q, fetch_cnt_d, flush_cnt_q, flush_cnt_d;
    logic [16:0] flush_sum;

    assign flush_sum = {1'b0, flush_cnt_q} + 17'(occ);

    always_comb begin
        fetch_cnt_d = (pop && fetch_cnt_q != 16'hFFFF) ? fetch_cnt_q + 1'b1 : fetch_cnt_q;
        flush_cnt_d = !redirect_valid ? flush_cnt_q : flush_sum[16] ? 16'hFFFF : flush_sum[15:0];
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            fetch_cnt_q <= '0;
            flush_cnt_q <= '0;
        end else begin
            fetch_cnt_q <= fetch_cnt_d;
            flush_cnt_q <= flush_cnt_d;
        end
    end

    assign fetch_cnt = fetch_cnt_q;
    assign flush_cnt = flush_cnt_q;
`else
    assign fetch_cnt = '0;
    assign flush_cnt = '0;
`endif
endmodule

// File: tb/tb_fetch_queue.sv
// tb_fetch_queue: directed cycle-exact checks of fetch, backpressure, redirect, PC wrap and reset.
module tb_fetch_queue;
    logic        clock = 1'b0;
    logic        reset_n = 1'b0;
    logic        redirect_valid = 1'b0;
    logic [31:0] redirect_pc = '0;
    logic [15:0] fc0, fl0, fc1, fl1;
    int          checks = 0;
    int          errors = 0;

`ifdef FETCH_STATS_EN
    localparam bit STATS = 1'b1;
`else
    localparam bit STATS = 1'b0;
`endif

    fetch_queue_if b0 ();
    fetch_queue_if b1 ();

    fetch_queue u0 (
        .clock(clock), .reset_n(reset_n), .redirect_valid(redirect_valid),
        .redirect_pc(redirect_pc), .bus(b0), .fetch_cnt(fc0), .flush_cnt(fl0)
    );
    fetch_queue #(.RESET_PC(32'hFFFF_FFFE)) u1 (
        .clock(clock), .reset_n(reset_n), .redirect_valid(1'b0),
        .redirect_pc(32'd0), .bus(b1), .fetch_cnt(fc1), .flush_cnt(fl1)
    );

    always #5 clock = ~clock;

    // Instruction memory: word i holds i+100, one-cycle read latency.
    always_ff @(posedge clock) begin
        if (b0.imem_en) b0.imem_rdata <= 32'(b0.imem_addr) + 32'd100;
        if (b1.imem_en) b1.imem_rdata <= 32'(b1.imem_addr) + 32'd100;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic step(input int n);
        repeat (n) @(posedge clock);
        #3;
    endtask

    task automatic do_reset();
        reset_n = 1'b0;
        @(posedge clock);
        #2 reset_n = 1'b1;
        #1;
    endtask

    initial begin
        b0.out_ready = 1'b0;
        b1.out_ready = 1'b1;
        #3;
        chk("rst_valid", b0.out_valid, 0);
        chk("rst_en", b0.imem_en, 0);
        chk("rst_pc", b0.out_pc, 0);
        chk("rst_instr", b0.out_instr, 0);
        chk("rst_fcnt", fc0, 0);
        chk("rst_flcnt", fl0, 0);

        // Streaming at one per cycle, plus the wrapping instance
        b0.out_ready = 1'b1;
        do_reset();
        chk("t1_idle_en", b0.imem_en, 0);
        step(1);
        chk("t1_en", b0.imem_en, 1);
        chk("t1_addr", b0.imem_addr, 0);
        chk("t5_addr0", b1.imem_addr, 32'hFE);
        step(1);
        chk("t1_nv2", b0.out_valid, 0);
        chk("t5_addr1", b1.imem_addr, 32'hFF);
        step(1);
        chk("t1_v3", b0.out_valid, 1);
        chk("t1_pc3", b0.out_pc, 0);
        chk("t1_in3", b0.out_instr, 100);
        chk("t5_addr2", b1.imem_addr, 32'h00);
        chk("t5_pc0", b1.out_pc, 32'hFFFF_FFFE);
        chk("t5_in0", b1.out_instr, 354);
        step(1);
        chk("t1_pc4", b0.out_pc, 1);
        chk("t1_in4", b0.out_instr, 101);
        chk("t5_pc1", b1.out_pc, 32'hFFFF_FFFF);
        step(1);
        chk("t1_pc5", b0.out_pc, 2);
        chk("t1_in5", b0.out_instr, 102);
        chk("t5_pc2", b1.out_pc, 0);
        chk("t5_in2", b1.out_instr, 100);
        step(1);
        chk("t1_fcnt", fc0, STATS ? 3 : 0);
        chk("t5_fcnt", fc1, STATS ? 3 : 0);

        // Backpressure: credit stops fetch at four, release drains in order
        b0.out_ready = 1'b0;
        do_reset();
        step(5);
        chk("t2_en5", b0.imem_en, 0);
        step(5);
        chk("t2_v10", b0.out_valid, 1);
        chk("t2_pc10", b0.out_pc, 0);
        chk("t2_en10", b0.imem_en, 0);
        step(2);
        b0.out_ready = 1'b1;
        #1;
        chk("t2_pc12", b0.out_pc, 0);
        chk("t2_en12", b0.imem_en, 0);
        for (int k = 1; k <= 4; k++) begin
            step(1);
            chk("t2_v", b0.out_valid, 1);
            chk("t2_pc", b0.out_pc, 32'(k));
            if (k == 1) begin
                chk("t2_en13", b0.imem_en, 1);
                chk("t2_addr13", b0.imem_addr, 4);
            end
        end

        // Redirect with 3 queued + 1 in flight
        b0.out_ready = 1'b0;
        do_reset();
        step(5);
        chk("t3_v_pre", b0.out_valid, 1);
        redirect_valid = 1'b1;
        redirect_pc = 32'd40;
        #1;
        chk("t3_v_now", b0.out_valid, 0);
        step(1);
        redirect_valid = 1'b0;
        b0.out_ready = 1'b1;
        #1;
        chk("t3_en_bub", b0.imem_en, 0);
        chk("t3_v6", b0.out_valid, 0);
        chk("t3_flcnt", fl0, STATS ? 4 : 0);
        step(1);
        chk("t3_en7", b0.imem_en, 1);
        chk("t3_addr7", b0.imem_addr, 40);
        step(1);
        chk("t3_v8", b0.out_valid, 0);
        step(1);
        chk("t3_v9", b0.out_valid, 1);
        chk("t3_pc9", b0.out_pc, 40);
        chk("t3_in9", b0.out_instr, 140);
        step(1);
        chk("t3_pc10", b0.out_pc, 41);

        // Back-to-back redirects: only the second target survives
        step(1);
        redirect_valid = 1'b1;
        redirect_pc = 32'd20;
        #1;
        step(1);
        redirect_pc = 32'd60;
        #1;
        chk("t4_en12", b0.imem_en, 0);
        step(1);
        redirect_valid = 1'b0;
        #1;
        chk("t4_en13", b0.imem_en, 0);
        chk("t4_v13", b0.out_valid, 0);
        chk("t4_flcnt", fl0, STATS ? 6 : 0);
        chk("t4_fcnt", fc0, STATS ? 2 : 0);
        step(1);
        chk("t4_en14", b0.imem_en, 1);
        chk("t4_addr14", b0.imem_addr, 60);
        step(1);
        chk("t4_v15", b0.out_valid, 0);
        step(1);
        chk("t4_pc16", b0.out_pc, 60);
        step(1);
        chk("t4_pc17", b0.out_pc, 61);

        // Asynchronous reset with a full, draining queue
        b0.out_ready = 1'b0;
        do_reset();
        step(8);
        chk("t6_v8", b0.out_valid, 1);
        b0.out_ready = 1'b1;
        step(1);
        chk("t6_en9", b0.imem_en, 1);
        chk("t6_pc9", b0.out_pc, 1);
        reset_n = 1'b0;
        #1;
        chk("t6_v_rst", b0.out_valid, 0);
        chk("t6_en_rst", b0.imem_en, 0);
        chk("t6_pc_rst", b0.out_pc, 0);
        chk("t6_in_rst", b0.out_instr, 0);
        do_reset();
        step(1);
        chk("t6_en1", b0.imem_en, 1);
        chk("t6_addr1", b0.imem_addr, 0);
        step(2);
        chk("t6_pc3", b0.out_pc, 0);
        chk("t6_in3", b0.out_instr, 100);
        chk("t5_flcnt", fl1, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
